// File: rtl/qos_wrr.sv
// qos_wrr -- multi-class QoS buffer with weighted round-robin read arbitration.
//
// Each incoming word is steered into one of NUM_Q FIFOs by its top QW bits.
// A WRR arbiter drains the FIFOs through a single registered read port. The
// block also produces flow-control hints and per-class served-word counters.
//
// Ports:
//   CLK, RESET        clock (rising edge), asynchronous active-low reset
//   DATA_IN, WRITE    write word and strobe; DATA_IN[DATA_W-1 -: QW] picks the queue
//   READ              pop request, served by the WRR arbiter
//   INIT              flush queues and load CFG_* while asserted
//   CFG_WEIGHT        per-queue weights, queue i at [i*WGT_W +: WGT_W] (0 acts as 1)
//   CFG_AF, CFG_AE    almost-full / almost-empty thresholds
//   REQ_SEL           selects the served-word counter shown on REQ_CNT
//   DATA_OUT, VALID   popped word, valid for one cycle after the popping edge
//   PAUSE, CONTINUE   some queue >= AF / every queue <= AE
//   ERROR             sticky overflow flag
//   STATE             RST=0, INIT=1, IDLE=2, ACTIVE=3, ERR=4
//   REQ_CNT           served-word counter of queue REQ_SEL, one cycle of latency
module qos_wrr #(
  parameter int DATA_W = 8,
  parameter int NUM_Q  = 4,
  parameter int DEPTH  = 4,
  parameter int WGT_W  = 4,
  parameter int CNT_W  = 5,
  localparam int QW = $clog2(NUM_Q),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [DATA_W-1:0]      DATA_IN,
  input  logic                   WRITE,
  input  logic                   READ,
  input  logic                   INIT,
  input  logic [NUM_Q*WGT_W-1:0] CFG_WEIGHT,
  input  logic [AW:0]            CFG_AF,
  input  logic [AW:0]            CFG_AE,
  input  logic [QW-1:0]          REQ_SEL,
  output logic [DATA_W-1:0]      DATA_OUT,
  output logic                   VALID,
  output logic                   PAUSE,
  output logic                   CONTINUE,
  output logic                   ERROR,
  output logic [2:0]             STATE,
  output logic [CNT_W-1:0]       REQ_CNT
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_mem    [NUM_Q][DEPTH];
  logic [AW-1:0]     r_wptr   [NUM_Q];
  logic [AW-1:0]     r_rptr   [NUM_Q];
  logic [AW:0]       r_cnt    [NUM_Q];
  logic [CNT_W-1:0]  r_served [NUM_Q];
  logic [WGT_W-1:0]  r_weight [NUM_Q];
  logic [AW:0]       r_af, r_ae;
  logic [QW-1:0]     r_cur;
  logic [WGT_W-1:0]  r_credit;
  logic [DATA_W-1:0] r_data_out;
  logic              r_valid, r_pause, r_continue, r_error;
  logic [CNT_W-1:0]  r_req_cnt;

  logic              w_in_init, w_op, w_wr_en, w_wr_acc, w_overflow, w_pop, w_any_nxt;
  logic              w_pause_nxt, w_cont_nxt;
  logic [QW-1:0]     w_wq, w_pop_q, w_adv_q, w_cur_nxt;
  logic [WGT_W-1:0]  w_weff, w_credit_inc, w_credit_nxt;
  logic [AW:0]       w_cnt_nxt    [NUM_Q];
  logic [WGT_W-1:0]  w_weight_nxt [NUM_Q];
  logic [AW:0]       w_af_nxt, w_ae_nxt;

  // NOTE: every combinational output gets a default at the top of the block so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_in_init = INIT || (r_state == S_INIT);
    w_op      = !w_in_init && (r_state inside {S_IDLE, S_ACTIVE, S_ERR});
    w_wq      = DATA_IN[DATA_W-1 -: QW];

    // Pop source: cur if it holds data, else the nearest non-empty queue after it.
    // Scanning downward lets the smallest offset win.
    w_pop   = 1'b0;
    w_pop_q = r_cur;
    if (w_op && READ) begin
      if (r_cnt[r_cur] != '0) begin
        w_pop = 1'b1;
      end else begin
        for (int k = NUM_Q-1; k >= 1; k--) begin
          if (r_cnt[r_cur + QW'(k)] != '0) begin
            w_pop   = 1'b1;
            w_pop_q = r_cur + QW'(k);
          end
        end
      end
    end

    // A full queue still accepts a write when it is popped on the same edge.
    w_wr_en    = w_op && WRITE && (r_state != S_ERR);
    w_wr_acc   = w_wr_en && ((r_cnt[w_wq] != FULL) || (w_pop && (w_pop_q == w_wq)));
    w_overflow = w_wr_en && !w_wr_acc;

    w_any_nxt   = 1'b0;
    for (int q = 0; q < NUM_Q; q++) begin
      w_cnt_nxt[q] = r_cnt[q];
      if (w_in_init) begin
        w_cnt_nxt[q] = '0;
      end else begin
        if (w_wr_acc && (w_wq == QW'(q)))   w_cnt_nxt[q] = w_cnt_nxt[q] + (AW+1)'(1);
        if (w_pop && (w_pop_q == QW'(q)))   w_cnt_nxt[q] = w_cnt_nxt[q] - (AW+1)'(1);
      end
      if (w_cnt_nxt[q] != '0) w_any_nxt = 1'b1;
      w_weight_nxt[q] = w_in_init ? CFG_WEIGHT[q*WGT_W +: WGT_W] : r_weight[q];
    end
    w_af_nxt = w_in_init ? CFG_AF : r_af;
    w_ae_nxt = w_in_init ? CFG_AE : r_ae;

    // Flags are computed from post-edge counts and thresholds so they line up
    // with the queue update.
    w_pause_nxt = 1'b0;
    w_cont_nxt  = 1'b1;
    for (int q = 0; q < NUM_Q; q++) begin
      if (w_cnt_nxt[q] >= w_af_nxt) w_pause_nxt = 1'b1;
      if (w_cnt_nxt[q] >  w_ae_nxt) w_cont_nxt  = 1'b0;
    end

    // Next non-empty queue after the popped one (post-edge counts); offset NUM_Q
    // is the popped queue itself, and with nothing left cur parks on it.
    w_adv_q = w_pop_q;
    for (int k = NUM_Q; k >= 1; k--) begin
      if (w_cnt_nxt[w_pop_q + QW'(k)] != '0) w_adv_q = w_pop_q + QW'(k);
    end

    w_weff       = (r_weight[w_pop_q] == '0) ? WGT_W'(1) : r_weight[w_pop_q];
    w_credit_inc = ((w_pop_q == r_cur) ? r_credit : '0) + WGT_W'(1);
    w_cur_nxt    = r_cur;
    w_credit_nxt = r_credit;
    if (w_in_init) begin
      w_cur_nxt    = '0;
      w_credit_nxt = '0;
    end else if (w_pop) begin
      if ((w_credit_inc >= w_weff) || (w_cnt_nxt[w_pop_q] == '0)) begin
        w_cur_nxt    = w_adv_q;
        w_credit_nxt = '0;
      end else begin
        w_cur_nxt    = w_pop_q;
        w_credit_nxt = w_credit_inc;
      end
    end

    w_state_nxt = r_state;
    if (INIT) begin
      w_state_nxt = S_INIT;
    end else begin
      case (r_state)
        S_RST:            w_state_nxt = S_INIT;
        S_INIT:           w_state_nxt = S_IDLE;
        S_IDLE, S_ACTIVE: w_state_nxt = w_overflow ? S_ERR : (w_any_nxt ? S_ACTIVE : S_IDLE);
        S_ERR:            w_state_nxt = S_ERR;
        default:          w_state_nxt = S_INIT;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy counts and pointers define
  // which entries are meaningful, so clearing the data itself buys nothing.
  always_ff @(posedge CLK) begin
    if (w_wr_acc) r_mem[w_wq][r_wptr[w_wq]] <= DATA_IN;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= S_RST;
      for (int q = 0; q < NUM_Q; q++) begin
        r_wptr[q]   <= '0;
        r_rptr[q]   <= '0;
        r_cnt[q]    <= '0;
        r_served[q] <= '0;
        r_weight[q] <= WGT_W'(1);
      end
      r_af       <= (AW+1)'(DEPTH-1);
      r_ae       <= (AW+1)'(1);
      r_cur      <= '0;
      r_credit   <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_pause    <= 1'b0;
      r_continue <= 1'b1;
      r_error    <= 1'b0;
      r_req_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      for (int q = 0; q < NUM_Q; q++) begin
        r_cnt[q]    <= w_cnt_nxt[q];
        r_weight[q] <= w_weight_nxt[q];
        if (w_in_init) begin
          r_wptr[q]   <= '0;
          r_rptr[q]   <= '0;
          r_served[q] <= '0;
        end else begin
          if (w_wr_acc && (w_wq == QW'(q))) r_wptr[q] <= r_wptr[q] + AW'(1);
          if (w_pop && (w_pop_q == QW'(q))) begin
            r_rptr[q]   <= r_rptr[q] + AW'(1);
            r_served[q] <= r_served[q] + CNT_W'(1);
          end
        end
      end
      r_af       <= w_af_nxt;
      r_ae       <= w_ae_nxt;
      r_cur      <= w_cur_nxt;
      r_credit   <= w_credit_nxt;
      r_valid    <= w_pop;
      if (w_pop) r_data_out <= r_mem[w_pop_q][r_rptr[w_pop_q]];
      r_pause    <= w_pause_nxt;
      r_continue <= w_cont_nxt;
      if (w_in_init)       r_error <= 1'b0;
      else if (w_overflow) r_error <= 1'b1;
      r_req_cnt  <= r_served[REQ_SEL];
    end
  end

  assign DATA_OUT = r_data_out;
  assign VALID    = r_valid;
  assign PAUSE    = r_pause;
  assign CONTINUE = r_continue;
  assign ERROR    = r_error;
  assign STATE    = r_state;
  assign REQ_CNT  = r_req_cnt;

endmodule

// File: doc/qos_wrr.md
# qos_wrr

Parametrised multi-class QoS buffer with weighted round-robin output arbitration. Incoming words are steered by their class bits into one of NUM_Q FIFOs. A WRR arbiter drains the FIFOs through a single read port. The block raises flow-control hints and keeps per-class served-word counters. It is the next-generation replacement for the fixed 8-bit QoS buffer in the project datapath, and its port style matches that block.

## Interface
Parameters:
- DATA_W, 8, word width; class field is DATA_IN[DATA_W-1 -: QW]
- NUM_Q, 4, number of class queues (power of 2, ≥2); QW = log2(NUM_Q)
- DEPTH, 4, words per queue (power of 2, ≥2); AW = log2(DEPTH)
- WGT_W, 4, width of each queue weight
- CNT_W, 5, width of served-word counters

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  asynchronous, active-low reset
- DATA_IN  in  DATA_W  write word; its top QW bits select the queue
- WRITE  in  1  write strobe; sampled on the edge
- READ  in  1  read request; sampled on the edge
- INIT  in  1  configuration/flush request
- CFG_WEIGHT  in  NUM_Q*WGT_W  per-queue weight; queue i uses slice [i*WGT_W +: WGT_W]
- CFG_AF  in  AW+1  almost-full threshold
- CFG_AE  in  AW+1  almost-empty threshold
- REQ_SEL  in  QW  selects which served-word counter is reported
- DATA_OUT  out  DATA_W  popped word (registered)
- VALID  out  1  DATA_OUT holds a word popped on the previous edge
- PAUSE  out  1  at least one queue has count ≥ AF
- CONTINUE  out  1  every queue has count ≤ AE
- ERROR  out  1  sticky overflow flag
- STATE  out  3  FSM state: RST=0, INIT=1, IDLE=2, ACTIVE=3, ERR=4
- REQ_CNT  out  CNT_W  served-word counter of queue REQ_SEL (registered)

## Operation
- Configuration registers: weights, AF and AE.
  - Reset defaults: weights all 1, AF = DEPTH-1, AE = 1.
  - Loaded every cycle while in INIT.
  - A weight of 0 is treated as 1.
- FSM transitions:
  - RST → INIT on the first edge after RESET deasserts.
  - Any state → INIT whenever INIT = 1.
  - INIT → IDLE once INIT = 0.
  - IDLE ↔ ACTIVE: ACTIVE while any queue is non-empty, IDLE when all are empty.
  - IDLE/ACTIVE → ERR when a write targets a full queue that is not popped in the same cycle.
  - ERR is left only through INIT.
- While in INIT: queues are flushed, counters and ERROR are cleared, and WRITE/READ are ignored.
- Write rules (IDLE, ACTIVE):
  - A write to a non-full queue is accepted.
  - A write to a full queue that is popped in the same cycle is also accepted; its count is unchanged.
  - Otherwise the word is dropped and ERROR is set.
  - In ERR, writes are ignored and reads are still served.
- Arbitration:
  - Arbiter state is a current queue `cur` and a `credit` counter.
  - On an accepted pop from `cur`, credit increments.
  - If credit reaches weight[cur], or `cur` becomes empty, `cur` advances to the next non-empty queue in cyclic order after `cur`, and credit resets to 0.
  - If `cur` is empty when READ arrives, the pop is taken from the next non-empty queue in cyclic order, which becomes `cur`.
- Read rules:
  - READ with all queues empty leaves VALID at 0 and DATA_OUT holding its value; this is not an error.
  - Each pop increments that queue's counter, which wraps modulo 2^CNT_W.
- Queue occupancy counts range 0..DEPTH (AW+1 bits); read and write pointers wrap modulo DEPTH.

## Timing
- Reset values: DATA_OUT = 0, VALID = 0, PAUSE = 0, CONTINUE = 1, ERROR = 0, STATE = RST, REQ_CNT = 0. All queues empty, `cur` = 0, credit = 0.
- Write latency: a word accepted on edge n is visible in the queue count after edge n, so it can be popped by a READ sampled on edge n+1.
- Read latency: a READ sampled on edge n puts the word on DATA_OUT with VALID = 1 after edge n; the data is valid for one cycle.
- A simultaneous write and pop on the same queue both take effect; count is unchanged.
- PAUSE, CONTINUE and STATE are registered, derived from post-edge counts, and lag the queue update by 0 cycles (computed from next-state).
- REQ_CNT is registered from REQ_SEL: one cycle of latency.
- An INIT or RESET asserted mid-stream discards queued data; VALID is 0 the cycle after.

## Test plan
- Reset, then INIT pulse with weights {1,1,1,1} → STATE goes RST → INIT → IDLE; CONTINUE = 1; all outputs at their reset values.
- Write 0x05, 0x45, 0x85, 0xC5 (one word per queue), then READ ×4 → DATA_OUT sequence 0x05, 0x45, 0x85, 0xC5, each with VALID = 1; STATE returns to IDLE.
- Weights {3,1,1,1}, fill q0 with 4 words and q1 with 2, continuous READ → served order q0, q0, q0, q1, q0, q1.
- Write 5 words to q2 with DEPTH = 4, AF = 3 → PAUSE = 1 after the 3rd write; the 5th write sets ERROR = 1 and STATE = ERR; READs still return the 4 stored words; INIT clears ERROR.
- Full q1 with a same-cycle WRITE and READ → the write is accepted, count stays at 4, ERROR remains 0.
- After 33 pops from q3 with CNT_W = 5 and REQ_SEL = 3 → REQ_CNT = 1 (wrapped), one cycle after REQ_SEL is set.
